// File: rtl/fir_stim_gen.sv
// Stimulus generator for a FIR under test: drives impulse/step/LFSR/alternating samples, then flushes
// and accumulates a checksum and signed peak of the FIR output over the drive and flush cycles.
module fir_stim_gen #(
  parameter int N_TAPS = 6,
  parameter int BW_in  = 6,
  parameter int BW_out = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic signed [BW_in-1:0]  amp,
  input  logic [7:0]               len,
  output logic signed [BW_in-1:0]  x_out,
  input  logic signed [BW_out-1:0] y_in,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              checksum,
  output logic signed [BW_out-1:0] peak
);

  localparam int CW = (N_TAPS > 255) ? $clog2(N_TAPS + 1) : 8;
  localparam logic [1:0] M_IMP  = 2'd0;
  localparam logic [1:0] M_STEP = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;
  localparam logic [1:0] M_ALT  = 2'd3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic signed [BW_out-1:0] PEAK_MIN = {1'b1, {(BW_out-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FLUSH, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [1:0]                mode_q, mode_d;
  logic signed [BW_in-1:0]   amp_q, amp_d;
  logic signed [BW_in-1:0]   x_q, x_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [15:0]               sum_q, sum_d;
  logic signed [BW_out-1:0]  peak_q, peak_d;

  logic [15:0]               lfsr_adv;
  logic [15:0]               y_ext;
  logic [15:0]               sum_acc;
  logic signed [BW_out-1:0]  peak_acc;

  // Fibonacci taps 16,14,13,11, shifting toward the MSB
  assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign y_ext    = {{(16-BW_out){y_in[BW_out-1]}}, y_in};
  assign sum_acc  = sum_q + y_ext;
  assign peak_acc = (y_in > peak_q) ? y_in : peak_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    amp_d   = amp_q;
    x_d     = x_q;
    lfsr_d  = lfsr_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        if (start) begin
          mode_d = mode;
          amp_d  = amp;
          sum_d  = '0;
          peak_d = PEAK_MIN;
          lfsr_d = LFSR_SEED;
          if (len != 8'd0) begin
            state_d = S_DRIVE;
            cnt_d   = CW'(len);
            x_d     = (mode == M_LFSR) ? LFSR_SEED[BW_in-1:0] : amp;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = CW'(N_TAPS);
          end
        end
      end
      S_DRIVE: begin
        sum_d  = sum_acc;
        peak_d = peak_acc;
        lfsr_d = lfsr_adv;
        if (cnt_q == CW'(1)) begin
          state_d = S_FLUSH;
          cnt_d   = CW'(N_TAPS);
          x_d     = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          case (mode_q)
            M_IMP:   x_d = '0;
            M_STEP:  x_d = amp_q;
            M_LFSR:  x_d = lfsr_adv[BW_in-1:0];
            M_ALT:   x_d = -x_q;
            default: x_d = '0;
          endcase
        end
      end
      S_FLUSH: begin
        sum_d  = sum_acc;
        peak_d = peak_acc;
        x_d    = '0;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        x_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= M_IMP;
      amp_q   <= '0;
      x_q     <= '0;
      lfsr_q  <= LFSR_SEED;
      sum_q   <= '0;
      peak_q  <= PEAK_MIN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      amp_q   <= amp_d;
      x_q     <= x_d;
      lfsr_q  <= lfsr_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
    end
  end

  assign x_out    = x_q;
  assign busy     = (state_q == S_DRIVE) || (state_q == S_FLUSH);
  assign done     = (state_q == S_DONE);
  assign checksum = sum_q;
  assign peak     = peak_q;

endmodule
